branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Parameters
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and PC width.
REQ-002 The block SHALL have parameter BHT_DEPTH, default 64, giving the number of 2-bit counter entries; it SHALL be a power of 2 and at least 4.
REQ-003 The block SHALL define IDX_W = log2(BHT_DEPTH) for internal use.

Interface
REQ-004 The block SHALL use one clock; reset is synchronous and active-low, on ports clk and rst_n.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 ex_valid_i  in  1  EX-stage instruction present.
REQ-008 ex_instr_i  in  32  EX-stage instruction word.
REQ-009 ex_pc_i  in  XLEN  EX-stage PC.
REQ-010 rs1_i, rs2_i  in  XLEN each  forwarded source operands.
REQ-011 ex_pred_taken_i  in  1  prediction made for this instruction at fetch.
REQ-012 stall_i  in  1  pipeline hold.
REQ-013 flush_i  in  1  kill the EX-stage instruction.
REQ-014 if_pc_i  in  XLEN  fetch-stage PC used for lookup.
REQ-015 if_pred_taken_o  out  1  combinational BHT prediction for if_pc_i.
REQ-016 res_valid_o  out  1  registered: a branch was resolved.
REQ-017 res_taken_o  out  1  registered: the resolved direction.
REQ-018 mispredict_o  out  1  registered: the resolved direction differs from the prediction.
REQ-019 redirect_pc_o  out  XLEN  registered: the correct next PC.
REQ-020 br_cnt_o, mis_cnt_o  out  32 each  counts of resolved branches and of mispredicts.

Function
REQ-021 A branch SHALL be defined as: ex_valid_i=1, ex_instr_i[6:0]=1100011, and funct3 = ex_instr_i[14:12] in {000, 001, 100, 101, 110, 111}.
- funct3 010 or 011 is not a branch: no capture, no update.
REQ-022 The branch conditions SHALL be:
- BEQ (000): rs1 == rs2.
- BNE (001): rs1 != rs2.
- BLT (100): rs1 < rs2, signed.
- BGE (101): rs1 >= rs2, signed.
- BLTU (110): rs1 < rs2, unsigned.
- BGEU (111): rs1 >= rs2, unsigned.
REQ-023 The branch target SHALL be ex_pc_i + sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- The sum wraps modulo 2^XLEN.
- Fall-through = ex_pc_i + 4, also wrapping.
REQ-024 Latency SHALL be one cycle: a branch presented in cycle N produces outputs valid in cycle N+1.
REQ-025 On each edge, flush_i=1 SHALL have the highest priority (after reset):
- res_valid_o and mispredict_o go to 0.
- No BHT update and no counter increment.
REQ-026 Otherwise, stall_i=1 SHALL hold all registered outputs, the BHT and both counters unchanged.
REQ-027 Otherwise, when a branch is present, the edge SHALL:
- set res_valid_o=1 and res_taken_o to the condition result;
- set redirect_pc_o = taken ? target : fall-through;
- set mispredict_o = (taken != ex_pred_taken_i);
- update the BHT and increment the counters.
REQ-028 Otherwise (no branch), res_valid_o and mispredict_o SHALL go to 0, and res_taken_o and redirect_pc_o SHALL hold their values.
REQ-029 BHT update rule:
- Index = ex_pc_i[IDX_W+1:2].
- The 2-bit counter saturates: taken increments, stopping at 11; not-taken decrements, stopping at 00.
REQ-030 if_pred_taken_o SHALL equal bit 1 of BHT[if_pc_i[IDX_W+1:2]].
- If an update to the same index occurs in the same cycle, the lookup returns the pre-update value (no bypass).
REQ-031 Counter updates:
- br_cnt_o increments by 1 per resolved branch.
- mis_cnt_o increments by 1 per mispredict.
- Both wrap from 2^32-1 to 0.

Reset
REQ-032 When rst_n=0 at a rising edge, the block SHALL:
- set res_valid_o, res_taken_o and mispredict_o to 0;
- set redirect_pc_o to 0;
- set br_cnt_o and mis_cnt_o to 0;
- set every BHT entry to 01 (weakly not-taken).
REQ-033 Reset SHALL override flush_i, stall_i and any branch in the same cycle.
- A branch presented during reset is lost.
REQ-034 After reset, if_pred_taken_o SHALL be 0 for every PC.

Verification
REQ-035 Signed vs unsigned: rs1=0xFFFFFFFF, rs2=0x00000001, with BLT then BLTU.
- BLT -> res_taken_o=1.
- BLTU -> res_taken_o=0.
- BGE and BGEU give the complements.
REQ-036 Target with negative offset: pc=0x00000100, BEQ with offset -8, rs1=rs2.
- Next cycle: res_valid_o=1, redirect_pc_o=0x000000F8.
- If ex_pred_taken_i=0: mispredict_o=1, mis_cnt_o=1.
REQ-037 BHT saturation at pc=0x40: three taken resolves.
- if_pred_taken_o for if_pc_i=0x40 goes 0 -> 1 after the first resolve, then stays 1.
- One not-taken resolve keeps it at 1; a second not-taken resolve makes it 0.
REQ-038 Stall then flush: branch with stall_i=1 for 2 cycles, then flush_i=1.
- Outputs and br_cnt_o are unchanged during the stall.
- After the flush edge, res_valid_o=0 and br_cnt_o is unchanged.
REQ-039 Reset mid-stream: assert rst_n=0 one cycle after a taken branch resolves.
- res_valid_o=0 and redirect_pc_o=0.
- Counters are 0.
- if_pred_taken_o=0 at the updated index.
REQ-040 Non-branch: funct3=010 and an opcode of 0110011 each give res_valid_o=0, with no BHT or counter change.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Resolves RISC-V conditional branches in EX with one-cycle registered results,
// and trains a bimodal table of 2-bit counters that fetch reads combinationally.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic [31:0]     ex_instr_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            ex_pred_taken_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_pred_taken_o,
  output logic            res_valid_o,
  output logic            res_taken_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     br_cnt_o,
  output logic [31:0]     mis_cnt_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_branch;
  logic             cond_taken;
  logic [12:0]      imm_b;
  logic [XLEN-1:0]  target_pc;
  logic [XLEN-1:0]  fallthru_pc;
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] if_idx;
  logic [1:0]       bht_cur;
  logic [1:0]       bht_next;
  logic             unused_bits;

  assign opcode = ex_instr_i[6:0];
  assign funct3 = ex_instr_i[14:12];

  // funct3 010 and 011 are the two reserved encodings under the branch opcode
  assign is_branch = ex_valid_i && (opcode == 7'b1100011) && (funct3[2:1] != 2'b01);

  assign imm_b       = {ex_instr_i[31], ex_instr_i[7], ex_instr_i[30:25], ex_instr_i[11:8], 1'b0};
  assign target_pc   = ex_pc_i + {{(XLEN-13){imm_b[12]}}, imm_b};
  assign fallthru_pc = ex_pc_i + XLEN'(4);

  assign ex_idx  = ex_pc_i[IDX_W+1:2];
  assign if_idx  = if_pc_i[IDX_W+1:2];
  assign bht_cur = bht[ex_idx];

  // Lookup reads the stored table, so a same-cycle update is not bypassed
  assign if_pred_taken_o = bht[if_idx][1];

  assign unused_bits = ^{ex_instr_i[24:15], if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

  always_comb begin
    cond_taken = 1'b0;
    case (funct3)
      3'b000:  cond_taken = (rs1_i == rs2_i);
      3'b001:  cond_taken = (rs1_i != rs2_i);
      3'b100:  cond_taken = ($signed(rs1_i) <  $signed(rs2_i));
      3'b101:  cond_taken = ($signed(rs1_i) >= $signed(rs2_i));
      3'b110:  cond_taken = (rs1_i <  rs2_i);
      3'b111:  cond_taken = (rs1_i >= rs2_i);
      default: cond_taken = 1'b0;
    endcase
  end

  always_comb begin
    bht_next = bht_cur;
    if (cond_taken && (bht_cur != 2'b11)) begin
      bht_next = bht_cur + 2'b01;
    end else if (!cond_taken && (bht_cur != 2'b00)) begin
      bht_next = bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_o   <= 1'b0;
      res_taken_o   <= 1'b0;
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
      br_cnt_o      <= '0;
      mis_cnt_o     <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (flush_i) begin
      res_valid_o  <= 1'b0;
      mispredict_o <= 1'b0;
    end else if (stall_i) begin
      res_valid_o <= res_valid_o;
    end else if (is_branch) begin
      res_valid_o   <= 1'b1;
      res_taken_o   <= cond_taken;
      mispredict_o  <= (cond_taken != ex_pred_taken_i);
      redirect_pc_o <= cond_taken ? target_pc : fallthru_pc;
      bht[ex_idx]   <= bht_next;
      br_cnt_o      <= br_cnt_o + 32'd1;
      if (cond_taken != ex_pred_taken_i) begin
        mis_cnt_o <= mis_cnt_o + 32'd1;
      end
    end else begin
      res_valid_o  <= 1'b0;
      mispredict_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the resolve unit.
module tb_branch_resolve_unit;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i;
  logic [31:0] ex_instr_i;
  logic [31:0] ex_pc_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        ex_pred_taken_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] if_pc_i;
  logic        if_pred_taken_o;
  logic        res_valid_o;
  logic        res_taken_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] br_cnt_o;
  logic [31:0] mis_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  bit          model_known = 1'b0;
  bit          m_valid;
  bit          m_taken;
  bit          m_mis;
  logic [31:0] m_redirect;
  logic [31:0] m_br;
  logic [31:0] m_mis_cnt;
  int          m_bht [DEPTH];

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid_i      (ex_valid_i),
    .ex_instr_i      (ex_instr_i),
    .ex_pc_i         (ex_pc_i),
    .rs1_i           (rs1_i),
    .rs2_i           (rs2_i),
    .ex_pred_taken_i (ex_pred_taken_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .if_pc_i         (if_pc_i),
    .if_pred_taken_o (if_pred_taken_o),
    .res_valid_o     (res_valid_o),
    .res_taken_o     (res_taken_o),
    .mispredict_o    (mispredict_o),
    .redirect_pc_o   (redirect_pc_o),
    .br_cnt_o        (br_cnt_o),
    .mis_cnt_o       (mis_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_branch(input logic [2:0] f3, input int offset);
    logic [12:0] imm;
    imm = offset[12:0];
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic int bht_index(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  // Architectural view of one clock edge, computed from the inputs just applied
  task automatic model_step();
    logic [2:0]         f3;
    bit                 is_br;
    bit                 tk;
    logic signed [12:0] imm;
    int                 off;
    int                 idx;
    if (!rst_n) begin
      model_known = 1'b1;
      m_valid = 0; m_taken = 0; m_mis = 0;
      m_redirect = 0; m_br = 0; m_mis_cnt = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
      return;
    end
    if (!model_known) return;
    f3    = ex_instr_i[14:12];
    is_br = ex_valid_i && (ex_instr_i[6:0] == 7'h63) && !(f3 inside {3'd2, 3'd3});
    if (flush_i) begin
      m_valid = 0;
      m_mis   = 0;
    end else if (stall_i) begin
      m_valid = m_valid;
    end else if (is_br) begin
      case (f3)
        3'd0:    tk = (rs1_i == rs2_i);
        3'd1:    tk = (rs1_i != rs2_i);
        3'd4:    tk = ($signed(rs1_i) < $signed(rs2_i));
        3'd5:    tk = !($signed(rs1_i) < $signed(rs2_i));
        3'd6:    tk = (rs1_i < rs2_i);
        default: tk = !(rs1_i < rs2_i);
      endcase
      imm = {ex_instr_i[31], ex_instr_i[7], ex_instr_i[30:25], ex_instr_i[11:8], 1'b0};
      off = imm;
      m_valid    = 1;
      m_taken    = tk;
      m_mis      = (tk != ex_pred_taken_i);
      m_redirect = tk ? (ex_pc_i + 32'(off)) : (ex_pc_i + 32'd4);
      idx = bht_index(ex_pc_i);
      if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
      else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
      m_br = m_br + 1;
      if (m_mis) m_mis_cnt = m_mis_cnt + 1;
    end else begin
      m_valid = 0;
      m_mis   = 0;
    end
  endtask

  task automatic applyStimulus(input bit rn, input bit v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                               input bit pred, input bit st, input bit fl, input logic [31:0] ifpc);
    rst_n = rn; ex_valid_i = v; ex_instr_i = instr; ex_pc_i = pc;
    rs1_i = a; rs2_i = b; ex_pred_taken_i = pred;
    stall_i = st; flush_i = fl; if_pc_i = ifpc;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (model_known) begin
      checkOutput("res_valid",   32'(res_valid_o),     32'(m_valid));
      checkOutput("res_taken",   32'(res_taken_o),     32'(m_taken));
      checkOutput("mispredict",  32'(mispredict_o),    32'(m_mis));
      checkOutput("redirect_pc", redirect_pc_o,        m_redirect);
      checkOutput("br_cnt",      br_cnt_o,             m_br);
      checkOutput("mis_cnt",     mis_cnt_o,            m_mis_cnt);
      checkOutput("if_pred",     32'(if_pred_taken_o), 32'(m_bht[bht_index(if_pc_i)] >= 2));
    end
  end

  initial begin
    logic [31:0] r_instr, r_pc, r_a, r_b, r_ifpc;
    bit          r_rn, r_v, r_p, r_st, r_fl;

    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h40);
    applyStimulus(0, 1, mk_branch(3'd0, 8), 32'h40, 5, 5, 0, 0, 0, 32'h40);
    checkOutput("rst_res_valid", 32'(res_valid_o), 0);
    checkOutput("rst_br_cnt", br_cnt_o, 0);
    checkOutput("rst_if_pred", 32'(if_pred_taken_o), 0);

    applyStimulus(1, 1, mk_branch(3'd0, -8), 32'h100, 5, 5, 0, 0, 0, 32'h40);
    checkOutput("neg_off_valid", 32'(res_valid_o), 1);
    checkOutput("neg_off_target", redirect_pc_o, 32'h0000_00F8);
    checkOutput("neg_off_mispredict", 32'(mispredict_o), 1);
    checkOutput("neg_off_mis_cnt", mis_cnt_o, 1);

    applyStimulus(1, 1, mk_branch(3'd4, 16), 32'h200, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 32'h40);
    checkOutput("blt_signed", 32'(res_taken_o), 1);
    applyStimulus(1, 1, mk_branch(3'd6, 16), 32'h200, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 32'h40);
    checkOutput("bltu_unsigned", 32'(res_taken_o), 0);
    checkOutput("bltu_fallthru", redirect_pc_o, 32'h204);
    applyStimulus(1, 1, mk_branch(3'd5, 16), 32'h200, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 32'h40);
    checkOutput("bge_signed", 32'(res_taken_o), 0);
    applyStimulus(1, 1, mk_branch(3'd7, 16), 32'h200, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 32'h40);
    checkOutput("bgeu_unsigned", 32'(res_taken_o), 1);
    checkOutput("bgeu_target", redirect_pc_o, 32'h210);

    checkOutput("sat_pred_initial", 32'(if_pred_taken_o), 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, mk_branch(3'd0, 16), 32'h40, 7, 7, 0, 0, 0, 32'h40);
      checkOutput("sat_pred_taken", 32'(if_pred_taken_o), 1);
    end
    checkOutput("sat_target", redirect_pc_o, 32'h50);
    applyStimulus(1, 1, mk_branch(3'd1, 16), 32'h40, 7, 7, 1, 0, 0, 32'h40);
    checkOutput("sat_pred_nt1", 32'(if_pred_taken_o), 1);
    applyStimulus(1, 1, mk_branch(3'd1, 16), 32'h40, 7, 7, 1, 0, 0, 32'h40);
    checkOutput("sat_pred_nt2", 32'(if_pred_taken_o), 0);
    checkOutput("sat_fallthru", redirect_pc_o, 32'h44);
    checkOutput("sat_br_cnt", br_cnt_o, 10);

    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, mk_branch(3'd0, 32), 32'h300, 1, 1, 0, 1, 0, 32'h40);
      checkOutput("stall_valid_held", 32'(res_valid_o), 1);
      checkOutput("stall_redirect_held", redirect_pc_o, 32'h44);
      checkOutput("stall_br_cnt", br_cnt_o, 10);
    end
    applyStimulus(1, 1, mk_branch(3'd0, 32), 32'h300, 1, 1, 0, 1, 1, 32'h40);
    checkOutput("flush_valid", 32'(res_valid_o), 0);
    checkOutput("flush_br_cnt", br_cnt_o, 10);

    r_instr = mk_branch(3'd2, 16);
    applyStimulus(1, 1, r_instr, 32'h80, 1, 1, 0, 0, 0, 32'h80);
    checkOutput("f3_010_valid", 32'(res_valid_o), 0);
    r_instr[6:0] = 7'b0110011;
    applyStimulus(1, 1, r_instr, 32'h80, 1, 1, 0, 0, 0, 32'h80);
    checkOutput("rtype_valid", 32'(res_valid_o), 0);
    checkOutput("nonbranch_br_cnt", br_cnt_o, 10);
    checkOutput("nonbranch_if_pred", 32'(if_pred_taken_o), 0);

    applyStimulus(1, 1, mk_branch(3'd0, 32), 32'h80, 3, 3, 0, 0, 0, 32'h80);
    checkOutput("pre_rst_target", redirect_pc_o, 32'hA0);
    checkOutput("pre_rst_if_pred", 32'(if_pred_taken_o), 1);
    applyStimulus(0, 1, mk_branch(3'd0, 32), 32'h80, 3, 3, 0, 0, 0, 32'h80);
    checkOutput("mid_rst_valid", 32'(res_valid_o), 0);
    checkOutput("mid_rst_redirect", redirect_pc_o, 0);
    checkOutput("mid_rst_br_cnt", br_cnt_o, 0);
    checkOutput("mid_rst_mis_cnt", mis_cnt_o, 0);
    checkOutput("mid_rst_if_pred", 32'(if_pred_taken_o), 0);

    applyStimulus(1, 1, mk_branch(3'd1, 8), 32'hFFFF_FFFC, 9, 9, 0, 0, 0, 32'h80);
    checkOutput("wrap_fallthru", redirect_pc_o, 32'h0);
    applyStimulus(1, 1, mk_branch(3'd0, 8), 32'hFFFF_FFFC, 9, 9, 1, 0, 0, 32'h80);
    checkOutput("wrap_target", redirect_pc_o, 32'h4);

    for (int c = 0; c < 4000; c++) begin
      r_rn = ($urandom_range(0, 199) != 0);
      r_v  = ($urandom_range(0, 3) != 0);
      r_p  = $urandom_range(0, 1);
      r_st = ($urandom_range(0, 5) == 0);
      r_fl = ($urandom_range(0, 9) == 0);
      r_instr = $urandom;
      if ($urandom_range(0, 7) != 0) r_instr[6:0] = 7'b1100011;
      case ($urandom_range(0, 9))
        0:       r_pc = $urandom;
        1:       r_pc = 32'hFFFF_FFFC - (32'($urandom_range(0, 7)) << 2);
        default: r_pc = 32'($urandom_range(0, 127)) << 2;
      endcase
      case ($urandom_range(0, 2))
        0: begin r_a = $urandom; r_b = $urandom; end
        1: begin r_a = $urandom; r_b = r_a; end
        default: begin
          r_a = 32'(int'($urandom_range(0, 4)) - 2);
          r_b = 32'(int'($urandom_range(0, 4)) - 2);
        end
      endcase
      r_ifpc = 32'($urandom_range(0, 127)) << 2;
      applyStimulus(r_rn, r_v, r_instr, r_pc, r_a, r_b, r_p, r_st, r_fl, r_ifpc);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
